// File: rtl/xillybus_stream_pkg.sv
// Shared types and helpers for the Xillybus read-stream packer.
// Holds the frame FSM state encoding and the statistics counter width.
package xillybus_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    DONE
  } state_e;

  localparam int STALL_W = 16;

  // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags, one-cycle read latency
// and a synchronous flush. DEPTH must be a power of two.
module stream_sync_fifo
  import xillybus_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             push, pop;

  assign push = wr_en & ~full_q;
  assign pop  = rd_en & ~empty_q;

  always_comb begin
    // NOTE: every signal gets its default first so no path leaves it unassigned (no latch).
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = mem[rd_ptr_q];
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      rd_data_q <= rd_data_d;
    end
  end

  // NOTE: storage array is not reset; pointers and count alone define its valid contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = rd_data_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/xillybus_rd_stream_packer.sv
// Packs framed IN_W samples into OUT_W words feeding one Xillybus read pipe.
// Optional build macro STREAM_STATS_EN adds the stall_cnt statistics port.
module xillybus_rd_stream_packer
  import xillybus_stream_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 64,
  parameter int LEN_W = 16
) (
  input  logic               bus_clk,
  input  logic               bus_rst,
  input  logic               frame_start,
  input  logic [LEN_W-1:0]   frame_len,
  output logic               busy,
  input  logic               smp_valid,
  output logic               smp_ready,
  input  logic [IN_W-1:0]    smp_data,
  input  logic               rd_rden,
  output logic [OUT_W-1:0]   rd_data,
  output logic               rd_empty,
  output logic               rd_eof,
  input  logic               rd_open
`ifdef STREAM_STATS_EN
  ,
  output logic [STALL_W-1:0] stall_cnt
`endif
);

  localparam int RATIO  = OUT_W / IN_W;
  localparam int SLOT_W = (RATIO > 1) ? clog2(RATIO) : 1;

  state_e             state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [OUT_W-1:0]   pack_q, pack_d, pack_ins;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic               fifo_full, fifo_empty, fifo_push, fifo_flush;
  logic               accept, last_smp, word_done, frame_go;

  // Ready is also withheld while the pipe is closed: those samples would be flushed anyway.
  assign smp_ready = (state_q == CAPTURE) & ~fifo_full & rd_open;
  assign accept    = smp_valid & smp_ready;
  assign last_smp  = (remain_q == LEN_W'(1));
  assign word_done = (slot_q == SLOT_W'(RATIO - 1)) | last_smp;
  assign frame_go  = (state_q == IDLE) & frame_start & rd_open & (frame_len != '0);

  always_comb begin
    pack_ins = pack_q;
    for (int i = 0; i < RATIO; i++) begin
      if (slot_q == SLOT_W'(i)) pack_ins[i*IN_W +: IN_W] = smp_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    pack_d     = pack_q;
    remain_d   = remain_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_go) begin
          state_d  = CAPTURE;
          remain_d = frame_len;
          slot_d   = '0;
          pack_d   = '0;
        end
      end
      CAPTURE: begin
        if (accept) begin
          remain_d = remain_q - LEN_W'(1);
          if (word_done) begin
            fifo_push = 1'b1;
            pack_d    = '0;
            slot_d    = '0;
          end else begin
            pack_d = pack_ins;
            slot_d = slot_q + SLOT_W'(1);
          end
          if (last_smp) state_d = DRAIN;
        end
      end
      DRAIN:   if (fifo_empty) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    // Host closing the file aborts everything and discards buffered data.
    if (!rd_open) begin
      state_d    = IDLE;
      slot_d     = '0;
      pack_d     = '0;
      remain_d   = '0;
      fifo_push  = 1'b0;
      fifo_flush = 1'b1;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      pack_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      pack_q   <= pack_d;
      remain_q <= remain_d;
    end
  end

  stream_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (bus_clk),
    .rst     (bus_rst),
    .flush   (fifo_flush),
    .wr_en   (fifo_push),
    .wr_data (pack_ins),
    .rd_en   (rd_rden),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign busy     = (state_q == CAPTURE) | (state_q == DRAIN);
  assign rd_empty = fifo_empty;
  assign rd_eof   = (state_q == DONE) & fifo_empty;

`ifdef STREAM_STATS_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (frame_go) begin
      stall_d = '0;
    end else if ((state_q == CAPTURE) & smp_valid & ~smp_ready & (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  // Statistics build option disabled: no stall counter.
`endif

endmodule
